// File: rtl/decode_stage_hz.sv
// MIPS instruction-decode stage with register file, hazard detection, branch/JR
// forwarding, IF/ID flush on redirect and a HALT drain state machine.
module decode_stage_hz #(
  parameter int         NB_BITS  = 32,
  parameter int         NB_REG   = 5,
  parameter int         NB_EXEC  = 9,
  parameter int         NB_DRAIN = 3,
  parameter logic [5:0] HALT_OP  = 6'h3F
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NB_BITS-1:0] i_pc,
  input  logic [NB_BITS-1:0] i_instr,
  input  logic [NB_BITS-1:0] i_wb_data,
  input  logic [NB_REG-1:0]  i_reg_dst,
  input  logic               i_wb_rf_webn,
  input  logic [NB_BITS-1:0] i_ex_mem_data,
  input  logic [NB_REG-1:0]  i_ex_mem_dst,
  input  logic               i_ex_mem_regwr,
  input  logic               i_ex_mem_memrd,
  output logic [NB_BITS-1:0] o_id_ex_pc,
  output logic [NB_BITS-1:0] o_id_ex_rs,
  output logic [NB_BITS-1:0] o_id_ex_rt,
  output logic [NB_BITS-1:0] o_id_ex_sgext,
  output logic [NB_REG-1:0]  o_id_ex_rt_num,
  output logic [NB_REG-1:0]  o_id_ex_rd_num,
  output logic [NB_REG-1:0]  o_id_ex_dst,
  output logic [NB_EXEC-1:0] o_id_ex_exec,
  output logic               o_id_ex_regwr,
  output logic               o_id_ex_memrd,
  output logic               o_id_ex_memwr,
  output logic               o_id_ex_valid,
  output logic               o_stall,
  output logic               o_flush,
  output logic               o_pc_src,
  output logic               o_pc_beq,
  output logic [NB_BITS-1:0] o_jmp_addr,
  output logic [NB_BITS-1:0] o_brh_addr,
  output logic               o_halted
);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;
  localparam int         CNT_W     = (NB_DRAIN > 1) ? $clog2(NB_DRAIN) : 1;

  logic [5:0]         opcode, func;
  logic [4:0]         shamt;
  logic [15:0]        imm;
  logic [NB_REG-1:0]  rs, rt, rd;
  logic [NB_BITS-1:0] sext, zext, shext;

  assign opcode = i_instr[31:26];
  assign rs     = NB_REG'(i_instr[25:21]);
  assign rt     = NB_REG'(i_instr[20:16]);
  assign rd     = NB_REG'(i_instr[15:11]);
  assign shamt  = i_instr[10:6];
  assign func   = i_instr[5:0];
  assign imm    = i_instr[15:0];
  assign sext   = {{(NB_BITS-16){imm[15]}}, imm};
  assign zext   = {{(NB_BITS-16){1'b0}}, imm};
  assign shext  = {{(NB_BITS-5){1'b0}}, shamt};

  // Register file; reads see a write-back landing on the same edge.
  logic [NB_BITS-1:0] rf_q [2**NB_REG];
  logic [NB_BITS-1:0] rf_rs, rf_rt, fwd_rs, fwd_rt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < 2**NB_REG; i++) rf_q[i] <= '0;
    end else if (i_wb_rf_webn && i_reg_dst != '0) begin
      rf_q[i_reg_dst] <= i_wb_data;
    end
  end

  assign rf_rs = (i_wb_rf_webn && i_reg_dst != '0 && i_reg_dst == rs) ? i_wb_data : rf_q[rs];
  assign rf_rt = (i_wb_rf_webn && i_reg_dst != '0 && i_reg_dst == rt) ? i_wb_data : rf_q[rt];

  // Loads are excluded: their EX/MEM value is an address, not the data.
  assign fwd_rs = (i_ex_mem_regwr && !i_ex_mem_memrd && rs != '0 && i_ex_mem_dst == rs)
                  ? i_ex_mem_data : rf_rs;
  assign fwd_rt = (i_ex_mem_regwr && !i_ex_mem_memrd && rt != '0 && i_ex_mem_dst == rt)
                  ? i_ex_mem_data : rf_rt;

  logic               valid_c, regwr_c, memrd_c, memwr_c;
  logic               use_rs, use_rt, is_br, is_bne, is_j, is_jr, is_halt;
  logic [3:0]         alu_op;
  logic [1:0]         rs_alu, rd_sel;
  logic               rt_alu;
  logic [NB_BITS-1:0] imm_c;
  logic [NB_REG-1:0]  dst_c;

  always_comb begin
    valid_c = 1'b0; regwr_c = 1'b0; memrd_c = 1'b0; memwr_c = 1'b0;
    use_rs  = 1'b0; use_rt  = 1'b0; is_br   = 1'b0; is_bne  = 1'b0;
    is_j    = 1'b0; is_jr   = 1'b0;
    alu_op  = 4'd0; rs_alu  = 2'b00; rt_alu = 1'b0; rd_sel  = 2'b00;
    imm_c   = sext;
    is_halt = (opcode == HALT_OP);
    case (opcode)
      6'h00: begin
        valid_c = 1'b1; use_rs = 1'b1; imm_c = shext;
        if (func == 6'h08) begin
          is_jr = 1'b1; alu_op = 4'd9;
        end else if (func == 6'h09) begin
          is_jr = 1'b1; regwr_c = 1'b1; rd_sel = 2'b10; rs_alu = 2'b10; alu_op = 4'd9;
        end else begin
          regwr_c = 1'b1; use_rt = 1'b1; rd_sel = 2'b01;
        end
      end
      6'h02: begin valid_c = 1'b1; is_j = 1'b1; alu_op = 4'd8; end
      6'h03: begin
        valid_c = 1'b1; is_j = 1'b1; regwr_c = 1'b1; rd_sel = 2'b10; rs_alu = 2'b10; alu_op = 4'd8;
      end
      6'h04, 6'h05: begin
        valid_c = 1'b1; use_rs = 1'b1; use_rt = 1'b1; is_br = 1'b1;
        is_bne = opcode[0]; alu_op = 4'd7;
      end
      6'h08: begin valid_c = 1'b1; regwr_c = 1'b1; use_rs = 1'b1; rt_alu = 1'b1; alu_op = 4'd1; end
      6'h0A: begin valid_c = 1'b1; regwr_c = 1'b1; use_rs = 1'b1; rt_alu = 1'b1; alu_op = 4'd2; end
      6'h0C: begin valid_c = 1'b1; regwr_c = 1'b1; use_rs = 1'b1; rt_alu = 1'b1; alu_op = 4'd3; imm_c = zext; end
      6'h0D: begin valid_c = 1'b1; regwr_c = 1'b1; use_rs = 1'b1; rt_alu = 1'b1; alu_op = 4'd4; imm_c = zext; end
      6'h0E: begin valid_c = 1'b1; regwr_c = 1'b1; use_rs = 1'b1; rt_alu = 1'b1; alu_op = 4'd5; imm_c = zext; end
      6'h0F: begin valid_c = 1'b1; regwr_c = 1'b1; rt_alu = 1'b1; alu_op = 4'd6; imm_c = zext; end
      6'h23: begin
        valid_c = 1'b1; regwr_c = 1'b1; memrd_c = 1'b1; use_rs = 1'b1; rt_alu = 1'b1; alu_op = 4'd1;
      end
      6'h2B: begin
        valid_c = 1'b1; memwr_c = 1'b1; use_rs = 1'b1; use_rt = 1'b1; rt_alu = 1'b1; alu_op = 4'd1;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (rd_sel)
      2'b01:   dst_c = rd;
      2'b10:   dst_c = NB_REG'(31);
      default: dst_c = rt;
    endcase
  end

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_use, br_hz, hz, run, halt_acc, redirect_en, stall_w;
  logic             br_src, rs_busy, rt_busy;

  assign load_use = o_id_ex_memrd && o_id_ex_dst != '0 &&
                    ((use_rs && o_id_ex_dst == rs) || (use_rt && o_id_ex_dst == rt));
  assign br_src   = is_br | is_jr;
  assign rs_busy  = rs != '0 && ((o_id_ex_regwr && o_id_ex_dst == rs) ||
                                 (i_ex_mem_memrd && i_ex_mem_dst == rs));
  assign rt_busy  = rt != '0 && ((o_id_ex_regwr && o_id_ex_dst == rt) ||
                                 (i_ex_mem_memrd && i_ex_mem_dst == rt));
  assign br_hz    = br_src && (rs_busy || (is_br && rt_busy));
  assign hz       = load_use | br_hz;

  assign run         = (state_q == ST_RUN);
  assign halt_acc    = run & is_halt & ~hz;
  assign stall_w     = hz | ~run | halt_acc;
  assign redirect_en = run & ~hz;

  assign o_stall    = stall_w;
  assign o_pc_src   = redirect_en & (is_j | is_jr);
  assign o_pc_beq   = redirect_en & is_br & ((fwd_rs == fwd_rt) ^ is_bne);
  assign o_flush    = o_pc_src | o_pc_beq;
  assign o_jmp_addr = is_jr ? fwd_rs : {i_pc[NB_BITS-1:28], i_instr[25:0], 2'b00};
  assign o_brh_addr = i_pc + {sext[NB_BITS-3:0], 2'b00};
  assign o_halted   = (state_q == ST_HALTED);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: if (halt_acc) begin
        state_d = ST_DRAIN;
        cnt_d   = '0;
      end
      ST_DRAIN: begin
        if (cnt_q == CNT_W'(NB_DRAIN - 1)) state_d = ST_HALTED;
        else cnt_d = cnt_q + CNT_W'(1);
      end
      ST_HALTED: ;
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ID/EX latch: a stall of any cause turns the control half into a bubble.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_id_ex_pc     <= '0;
      o_id_ex_rs     <= '0;
      o_id_ex_rt     <= '0;
      o_id_ex_sgext  <= '0;
      o_id_ex_rt_num <= '0;
      o_id_ex_rd_num <= '0;
      o_id_ex_dst    <= '0;
      o_id_ex_exec   <= '0;
      o_id_ex_regwr  <= 1'b0;
      o_id_ex_memrd  <= 1'b0;
      o_id_ex_memwr  <= 1'b0;
      o_id_ex_valid  <= 1'b0;
    end else begin
      o_id_ex_pc     <= i_pc;
      o_id_ex_rs     <= rf_rs;
      o_id_ex_rt     <= rf_rt;
      o_id_ex_sgext  <= imm_c;
      o_id_ex_rt_num <= rt;
      o_id_ex_rd_num <= rd;
      o_id_ex_dst    <= dst_c;
      o_id_ex_exec   <= stall_w ? '0 : NB_EXEC'({alu_op, rs_alu, rt_alu, rd_sel});
      o_id_ex_regwr  <= regwr_c & ~stall_w;
      o_id_ex_memrd  <= memrd_c & ~stall_w;
      o_id_ex_memwr  <= memwr_c & ~stall_w;
      o_id_ex_valid  <= valid_c & ~stall_w;
    end
  end

endmodule

// File: doc/decode_stage_hz.md
# decode_stage_hz

Second-generation MIPS instruction-decode (ID) stage, between the IF/ID latch and the execute stage. Decodes the instruction, reads a parametrised internal register file and registers operands and controls into the ID/EX latch. Adds what the first-generation decode lacked:
- load-use and branch-operand hazard detection with bubble insertion;
- EX/MEM forwarding into the in-ID branch comparator and JR target;
- explicit IF/ID flush on redirect;
- a HALT drain state machine.

## Interface

Parameters:
- NB_BITS, 32, datapath width.
- NB_REG, 5, register-index width; file holds 2**NB_REG registers, r0 reads 0 and ignores writes.
- NB_EXEC, 9, exec control word {alu_op[3:0], rs_alu[1:0], rt_alu, rd_sel[1:0]}.
- NB_DRAIN, 3, cycles to drain downstream pipeline after HALT.
- HALT_OP, 6'h3F, opcode of HALT.

Ports. Clock and reset: one clock; reset is synchronous and active-high.
- i_clk  in  1  clock, all state on rising edge.
- i_rst  in  1  synchronous active-high reset.
- i_pc  in  NB_BITS  PC+4 of instruction in IF/ID.
- i_instr  in  NB_BITS  instruction in IF/ID.
- i_wb_data, i_reg_dst, i_wb_rf_webn  in  NB_BITS/NB_REG/1  write-back port.
- i_ex_mem_data, i_ex_mem_dst, i_ex_mem_regwr, i_ex_mem_memrd  in  NB_BITS/NB_REG/1/1  EX/MEM result, destination, reg-write, is-load.
- o_id_ex_pc, o_id_ex_rs, o_id_ex_rt, o_id_ex_sgext  out  NB_BITS  latched PC, operands, extended immediate.
- o_id_ex_rt_num, o_id_ex_rd_num, o_id_ex_dst  out  NB_REG  latched rt, rd, resolved destination (rt, rd or 31).
- o_id_ex_exec  out  NB_EXEC  latched exec controls.
- o_id_ex_regwr, o_id_ex_memrd, o_id_ex_memwr, o_id_ex_valid  out  1  latched write/load/store/valid.
- o_stall  out  1  hold PC and IF/ID.
- o_flush  out  1  replace IF/ID with NOP next edge.
- o_pc_src  out  1  take jump target.
- o_pc_beq  out  1  take branch target.
- o_jmp_addr, o_brh_addr  out  NB_BITS  jump and branch targets.
- o_halted  out  1  pipeline drained after HALT.

## Operation

Opcodes:
- J 6'h02, JAL 6'h03, BEQ 6'h04, BNE 6'h05, ADDI 6'h08, SLTI 6'h0A, ANDI 6'h0C, ORI 6'h0D, XORI 6'h0E, LUI 6'h0F, LW 6'h23, SW 6'h2B, SPECIAL 6'h00 (JR func 6'h08, JALR func 6'h09).
- Unknown opcode decodes as bubble.

Immediates:
- Sign-extend for ADDI/SLTI/LW/SW/BEQ/BNE; zero-extend for ANDI/ORI/XORI/LUI; shamt zero-extended for SPECIAL.

Register file:
- Write on rising edge when i_wb_rf_webn=1 and i_reg_dst≠0.
- Same-cycle bypass: a read of i_reg_dst while writing returns i_wb_data.

Branch/JR operand forwarding:
- If i_ex_mem_regwr, !i_ex_mem_memrd and i_ex_mem_dst matches a nonzero source, use i_ex_mem_data; else use the file value.

Hazard (o_stall=1), all combinational:
- Load-use: o_id_ex_memrd and o_id_ex_dst≠0 equals rs, or equals rt for two-source instructions.
- Branch/JR on in-flight result: BEQ/BNE/JR/JALR source equals o_id_ex_dst with o_id_ex_regwr, or equals i_ex_mem_dst with i_ex_mem_memrd.
- While stalled, ID/EX loads a bubble: valid, regwr, memrd, memwr and exec all 0. o_pc_src, o_pc_beq and o_flush are forced 0.

Redirect (not stalled):
- J/JAL: o_pc_src=1, o_jmp_addr={i_pc[31:28], instr[25:0], 2'b00}.
- JR/JALR: o_pc_src=1, o_jmp_addr = forwarded rs.
- BEQ/BNE: o_pc_beq = (fwd_rs==fwd_rt) xor BNE; o_brh_addr = i_pc + (sgext<<2), modulo 2**NB_BITS.
- o_flush = o_pc_src | o_pc_beq.
- The redirecting instruction itself enters ID/EX; JAL/JALR latch dst=31 with regwr=1.

State machine:
- RUN: normal operation. HALT_OP while not stalled → DRAIN with count=0; ID/EX gets a bubble and o_stall=1 from then on.
- DRAIN: bubbles only; count increments each cycle; when count=NB_DRAIN-1 → HALTED.
- HALTED: o_halted=1, o_stall=1, bubbles. Only i_rst exits.

## Timing

- ID/EX latch: 1-cycle latency.
- o_stall, o_flush, o_pc_src, o_pc_beq and both target addresses are combinational in the same cycle.
- Reset, on the edge with i_rst=1:
  - all ID/EX outputs 0;
  - state RUN, count 0, o_halted 0;
  - register file cleared to 0.
- Reset mid-DRAIN or HALTED returns to RUN on that edge.
- Reset wins over a write-back in the same cycle.
- Stall has priority over redirect and HALT; a stalled HALT is accepted on the first unstalled cycle.
- A load followed by a dependent branch stalls 2 cycles: once on ID/EX, once on EX/MEM.

## Test plan

- Reset, then ADDI r1,r0,5; next cycle o_id_ex_sgext=5, o_id_ex_dst=1, o_id_ex_regwr=1, o_id_ex_valid=1.
- LW r2,0(r1) then ADD r3,r2,r2: o_stall=1 for exactly 1 cycle, ID/EX bubble with valid=0, then ADD latches normally.
- With EX/MEM forwarding r4=7 and file r5=7: BEQ r4,r5,+3 at i_pc=0x100 gives o_pc_beq=1, o_brh_addr=0x10C, o_flush=1. BNE with the same operands gives o_pc_beq=0.
- LW r6 then BEQ r6,r0: o_stall=1 for 2 cycles, then the branch resolves using the written-back value.
- JAL 0x0000040 at i_pc=0x00400004: o_jmp_addr=0x00000100, o_pc_src=1, o_flush=1, latched dst=31.
- HALT with NB_DRAIN=3: o_halted rises 3 cycles after HALT is accepted, o_stall stays 1. Assert i_rst during DRAIN → RUN, o_halted=0, o_stall=0.
